// File: rtl/shared_bus_mem.sv
// Word memory responding on the shared address_bus/data_bus initiator interface.
// Combinational bus reads, clocked bus writes, a registered host port for
// preload/dump, a zeroing sweep after reset, sticky flags and access counters.
module shared_bus_mem #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATABUS_WIDTH = 32,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_sel,
  input  logic                     mem_w,
  inout  wire  [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  input  logic                     host_we,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  input  logic [DATABUS_WIDTH-1:0] host_wdata,
  output logic [DATABUS_WIDTH-1:0] host_rdata,
  output logic                     ready,
  output logic                     addr_err,
  output logic                     host_conflict,
  output logic [CNT_WIDTH-1:0]     rd_count,
  output logic [CNT_WIDTH-1:0]     wr_count
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATABUS_WIDTH;
  localparam int unsigned CW = CNT_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam bit FULL_RANGE = (DEPTH == (1 << AW));

  typedef enum logic [0:0] {
    CLEAR  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ready_q, ready_d;
  logic          addr_err_q, addr_err_d;
  logic          conflict_q, conflict_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [DW-1:0] hrdata_q, hrdata_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic [DW-1:0] mem_wdata_c;
  logic          bus_ok_c;
  logic          host_ok_c;
  logic          bus_rd_c;
  logic          bus_wr_c;
  logic          drive_c;
  logic [DW-1:0] bus_word_c;
  logic [DW-1:0] host_word_c;
  logic [DW-1:0] bus_rdata_c;

  // Address range decode; a full-size array has no out-of-range addresses.
  generate
    if (FULL_RANGE) begin : g_full
      assign bus_ok_c  = 1'b1;
      assign host_ok_c = 1'b1;
    end else begin : g_part
      assign bus_ok_c  = (address_bus < AW'(DEPTH));
      assign host_ok_c = (host_addr < AW'(DEPTH));
    end
  endgenerate

  assign bus_rd_c    = mem_sel & ~mem_w;
  assign bus_wr_c    = mem_sel & mem_w;
  assign bus_word_c  = mem_q[address_bus];
  assign host_word_c = mem_q[host_addr];
  assign bus_rdata_c = bus_ok_c ? bus_word_c : '0;

  // Bus read data is driven only while an ACTIVE read is in progress.
  assign drive_c  = ~rst & (state_q == ACTIVE) & bus_rd_c;
  assign data_bus = drive_c ? bus_rdata_c : 'z;

  // Next-state, single write-port arbitration, flag and counter updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ready_d     = ready_q;
    addr_err_d  = addr_err_q;
    conflict_d  = conflict_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    hrdata_d    = '0;
    mem_we_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = '0;

    case (state_q)
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = ptr_q;
        if (ptr_q == LAST_ADDR) begin
          state_d = ACTIVE;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end

      ACTIVE: begin
        hrdata_d = host_ok_c ? host_word_c : '0;

        // The bus owns the write port; a concurrent host write is lost.
        if (bus_wr_c) begin
          if (bus_ok_c) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = address_bus;
            mem_wdata_c = data_bus;
            if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + CW'(1);
          end else begin
            addr_err_d = 1'b1;
          end
          if (host_we) conflict_d = 1'b1;
        end else if (host_we && host_ok_c) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = host_addr;
          mem_wdata_c = host_wdata;
        end

        if (host_we && !host_ok_c) addr_err_d = 1'b1;

        if (bus_rd_c) begin
          if (bus_ok_c) begin
            if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + CW'(1);
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Control registers with synchronous reset restarting the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
      conflict_q <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ready_q    <= ready_d;
      addr_err_q <= addr_err_d;
      conflict_q <= conflict_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      hrdata_q   <= hrdata_d;
    end
  end

  // Storage array, single write port; nothing commits in a reset cycle.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  assign host_rdata    = hrdata_q;
  assign ready         = ready_q;
  assign addr_err      = addr_err_q;
  assign host_conflict = conflict_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule

// File: doc/shared_bus_mem.md
# shared_bus_mem

Single-port word memory that acts as the responder on the shared `address_bus`/`data_bus` memory interface driven by the layer engines (pooling, convolution). It serves combinational reads and clocked writes to initiators, and offers a host-side port for preload and dump. Also provides a zero-initialising clear sweep after reset, sticky error/conflict flags and access counters for the test harness.

## Interface
- `ADDR_WIDTH`, 8: width of `address_bus` and `host_addr`.
- `DATABUS_WIDTH`, 32: word width of `data_bus` and the storage array.
- `DEPTH`, 256: number of stored words, with `DEPTH <= 2**ADDR_WIDTH`. Addresses `>= DEPTH` are out of range.
- `CNT_WIDTH`, 16: width of the access counters.
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `mem_sel`  in  1  initiator selects memory this cycle.
- `mem_w`  in  1  1 = write, 0 = read. Only meaningful while `mem_sel`=1.
- `address_bus`  inout  ADDR_WIDTH  word address. Always input to this block.
- `data_bus`  inout  DATABUS_WIDTH  write data in, or read data out.
- `host_we`  in  1  host write strobe.
- `host_addr`  in  ADDR_WIDTH  host address.
- `host_wdata`  in  DATABUS_WIDTH  host write data.
- `host_rdata`  out  DATABUS_WIDTH  registered host read data.
- `ready`  out  1  clear sweep complete; bus accesses are serviced.
- `addr_err`  out  1  sticky: an out-of-range bus or host access occurred.
- `host_conflict`  out  1  sticky: a host write was dropped because of a bus write in the same cycle.
- `rd_count`, `wr_count`  out  CNT_WIDTH  serviced bus read and write cycles. Both saturate.

## Operation
- State machine `CLEAR` -> `ACTIVE`.
- `rst` forces `CLEAR` with the clear pointer at 0. Every synchronous reset restarts the sweep, including a reset during `CLEAR`.
- `CLEAR`:
  - Writes 0 to word[ptr] each cycle and increments ptr.
  - After writing word `DEPTH-1`, moves to `ACTIVE`.
  - Bus and host requests are ignored, and `data_bus` stays Z.
  - `host_rdata` holds 0.
- `ACTIVE` read (`mem_sel`=1, `mem_w`=0):
  - `data_bus` is driven combinationally with word[`address_bus`] in the same cycle. The initiator samples it at the next edge.
  - An out-of-range read drives all zeros and sets `addr_err`.
  - Back-to-back reads with a new address every cycle are supported at one word per cycle.
- `ACTIVE` write (`mem_sel`=1, `mem_w`=1):
  - At the rising edge, word[`address_bus`] <= `data_bus`.
  - `data_bus` is never driven.
  - An out-of-range write is dropped and sets `addr_err`.
- When `mem_sel`=0, `data_bus` is Z. `mem_w` alone (without `mem_sel`) has no effect.
- Host port, `ACTIVE` only:
  - `host_rdata` <= word[`host_addr`] every cycle, or 0 if out of range.
  - With `host_we`=1, word[`host_addr`] <= `host_wdata`. An out-of-range host write is dropped and sets `addr_err`.
- Simultaneous bus write and host write in the same cycle:
  - The bus write wins.
  - The host write is dropped and `host_conflict` is set, even if the two addresses differ (single write port).
- Simultaneous host read of an address being written that cycle returns the old contents.
- Counters:
  - `rd_count` increments on each in-range bus read cycle; `wr_count` on each in-range bus write cycle.
  - Both stick at all-ones.
  - Host accesses are not counted.
- Reset values: `ready`=0, `addr_err`=0, `host_conflict`=0, `rd_count`=0, `wr_count`=0, `host_rdata`=0, `data_bus`=Z.

## Timing
- `CLEAR` lasts exactly `DEPTH` cycles after the cycle in which `rst` is sampled high. `ready` rises at the following edge.
- Read latency is 0 cycles: combinational, valid in the cycle `mem_sel` is high.
- Write commits at the edge that samples `mem_sel`=1 and `mem_w`=1. A read of the same address in the next cycle returns the new data.
- `host_rdata` latency is 1 cycle.
- Flags and counters update at the same edge that services the access.

## Test plan
- Reset, then release: `ready`=0 for 256 cycles and 1 on the next cycle. Bus reads of addresses 0, 128 and 255 return 0x00000000. `rd_count`=3.
- Write 0x0000002A to address 5 with a single `mem_sel` pulse, then read address 5 on the next cycle: `data_bus`=0x0000002A, `wr_count`=1.
- Host preload words 0..15 with values 1..16, then a 16-cycle bus burst read with the address incrementing every cycle. The bus returns 1..16 in order, `rd_count`=16, and no flags are set.
- With `DEPTH`=200:
  - Bus read of address 210: returns 0, `addr_err`=1.
  - Bus write of 0xFF to address 210: dropped, and host read of address 210 returns 0.
  - `addr_err` stays 1 until `rst`.
- Same-cycle bus write of 0xAA and host write of 0xBB, both to address 3: word 3 = 0xAA and `host_conflict`=1.
- Assert `rst` 100 cycles into `CLEAR`, then hold 1 cycle: `ready` stays 0 for a further 256 cycles. A bus write attempted during `CLEAR` is not stored and `wr_count` stays 0.
